// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and writeback
// over a shared ALU and unified memory port, with a memory-stall timeout and sticky trap.
module multicycle_control_unit #(
    parameter int unsigned ALUCTRL_W    = 3,
    parameter int unsigned ENABLE_JAL   = 1,
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7,
    input  logic                 ZeroF,
    input  logic                 SignF,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           state,
    output logic                 trap,
    output logic [1:0]           trap_cause
);

    localparam int unsigned CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    state_e           state_q, state_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [2:0]       alu_dec;
    logic [2:0]       alu_ctl;
    logic             taken;
    logic             waiting;
    logic             timeout;
    logic             pc_write, ir_write, mem_write, reg_write;

    // funct3 selects the ALU op; only R-type with bit 30 set turns 000 into sub
    always_comb begin
        alu_dec = funct3;
        if (funct3 == 3'b000) begin
            alu_dec = (op[5] && funct7) ? 3'b010 : 3'b000;
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = ZeroF;
            3'b001:  taken = !ZeroF;
            3'b100:  taken = SignF;
            3'b101:  taken = !SignF;
            default: taken = 1'b0;
        endcase
    end

    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE))
                     && !mem_ready;
    assign timeout = (WAIT_TIMEOUT != 0) && waiting && (stall_q == CNT_W'(WAIT_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        stall_d   = '0;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ImmSrc    = 2'b00;
        alu_ctl   = 3'b000;

        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? 2'b11 : 2'b10;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL: begin
                        if (ENABLE_JAL != 0) begin
                            state_d = S_JAL;
                        end else begin
                            state_d = S_TRAP;
                            cause_d = 2'b01;
                        end
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? 2'b01 : 2'b00;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_ctl = alu_dec;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_ctl = alu_dec;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 2'b10;
                alu_ctl  = 3'b010;
                pc_write = taken;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // a ready memory in the same cycle always wins over the timeout
        if (timeout) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
        end else if (waiting && (WAIT_TIMEOUT != 0)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (state_d == S_TRAP) trap_d = 1'b1;
    end

    // enables are forced low for the whole reset, even when it lands mid-instruction
    assign PCWrite    = pc_write & rst_n;
    assign IRWrite    = ir_write & rst_n;
    assign MemWrite   = mem_write & rst_n;
    assign RegWrite   = reg_write & rst_n;
    assign ALUControl = ALUCTRL_W'(alu_ctl);
    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two configurations driven in lockstep and
// compared every cycle against an instruction-level reference model.
module tb_multicycle_control_unit;

    localparam int A_TO  = 0;
    localparam int B_TO  = 2;
    localparam int A_JAL = 1;
    localparam int B_JAL = 0;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3;
    localparam int ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7;
    localparam int ST_ALUWB = 8, ST_BRANCH = 9, ST_JAL = 10, ST_TRAP = 11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       ZeroF;
    logic       SignF;
    logic       mem_ready;

    logic       PCWrite_a, AdrSrc_a, MemWrite_a, IRWrite_a, RegWrite_a, trap_a;
    logic [1:0] ResultSrc_a, ALUSrcA_a, ALUSrcB_a, ImmSrc_a, cause_a;
    logic [2:0] ALUControl_a;
    logic [3:0] state_a;

    logic       PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b, trap_b;
    logic [1:0] ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b, cause_b;
    logic [4:0] ALUControl_b;
    logic [3:0] state_b;

    int checks = 0;
    int errors = 0;

    int         m_st[2];
    logic       m_trap[2];
    logic [1:0] m_cause[2];
    int         m_run[2];

    multicycle_control_unit #(.ALUCTRL_W(3), .ENABLE_JAL(A_JAL), .WAIT_TIMEOUT(A_TO)) u_a (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .ZeroF(ZeroF), .SignF(SignF), .mem_ready(mem_ready),
        .PCWrite(PCWrite_a), .AdrSrc(AdrSrc_a), .MemWrite(MemWrite_a), .IRWrite(IRWrite_a),
        .RegWrite(RegWrite_a), .ResultSrc(ResultSrc_a), .ALUSrcA(ALUSrcA_a),
        .ALUSrcB(ALUSrcB_a), .ImmSrc(ImmSrc_a), .ALUControl(ALUControl_a),
        .state(state_a), .trap(trap_a), .trap_cause(cause_a)
    );

    multicycle_control_unit #(.ALUCTRL_W(5), .ENABLE_JAL(B_JAL), .WAIT_TIMEOUT(B_TO)) u_b (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .ZeroF(ZeroF), .SignF(SignF), .mem_ready(mem_ready),
        .PCWrite(PCWrite_b), .AdrSrc(AdrSrc_b), .MemWrite(MemWrite_b), .IRWrite(IRWrite_b),
        .RegWrite(RegWrite_b), .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b),
        .ALUSrcB(ALUSrcB_b), .ImmSrc(ImmSrc_b), .ALUControl(ALUControl_b),
        .state(state_b), .trap(trap_b), .trap_cause(cause_b)
    );

    logic [24:0] obs_a, obs_b;
    assign obs_a = {PCWrite_a, AdrSrc_a, MemWrite_a, IRWrite_a, RegWrite_a, ResultSrc_a,
                    ALUSrcA_a, ALUSrcB_a, ImmSrc_a, 2'b00, ALUControl_a, state_a, trap_a, cause_a};
    assign obs_b = {PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b, ResultSrc_b,
                    ALUSrcA_b, ALUSrcB_b, ImmSrc_b, ALUControl_b, state_b, trap_b, cause_b};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset(input int d);
        m_st[d]    = ST_FETCH;
        m_trap[d]  = 1'b0;
        m_cause[d] = 2'b00;
        m_run[d]   = 0;
    endfunction

    // Expected output word for the modelled state and the current inputs.
    function automatic logic [24:0] exp_word(input int d);
        logic       pcw, adr, mw, irw, rw, tk;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu, rule;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
        rs = 0; sa = 0; sb = 0; imm = 0; alu = 0;
        rule = (funct3 == 3'd0) ? ((op[5] && funct7) ? 3'd2 : 3'd0) : funct3;
        case (funct3)
            3'd0: tk = ZeroF;
            3'd1: tk = !ZeroF;
            3'd4: tk = SignF;
            3'd5: tk = !SignF;
            default: tk = 1'b0;
        endcase
        case (m_st[d])
            ST_FETCH:    begin sb = 2; rs = 2; pcw = mem_ready; irw = mem_ready; end
            ST_DECODE:   begin sa = 1; sb = 1; imm = (op == OP_JAL) ? 2'd3 : 2'd2; end
            ST_MEMADR:   begin sa = 2; sb = 1; imm = op[5] ? 2'd1 : 2'd0; end
            ST_MEMREAD:  adr = 1;
            ST_MEMWB:    begin rs = 1; rw = 1; end
            ST_MEMWRITE: begin adr = 1; mw = 1; end
            ST_EXECR:    begin sa = 2; alu = rule; end
            ST_EXECI:    begin sa = 2; sb = 1; alu = rule; end
            ST_ALUWB:    rw = 1;
            ST_BRANCH:   begin sa = 2; alu = 3'd2; pcw = tk; end
            ST_JAL:      begin sa = 1; sb = 2; pcw = 1; end
            default:     ;
        endcase
        return {pcw & rst_n, adr, mw & rst_n, irw & rst_n, rw & rst_n, rs, sa, sb, imm,
                5'(alu), 4'(m_st[d]), m_trap[d], m_cause[d]};
    endfunction

    // One clock of instruction progress; a wait longer than the configured limit traps.
    function automatic void model_step(input int d);
        int s, ns, to, jal_en;
        bit stalled, timed_out;
        if (!rst_n) begin
            model_reset(d);
            return;
        end
        s      = m_st[d];
        to     = (d == 0) ? A_TO : B_TO;
        jal_en = (d == 0) ? A_JAL : B_JAL;
        stalled = (s == ST_FETCH || s == ST_MEMREAD || s == ST_MEMWRITE) && !mem_ready;
        case (s)
            ST_FETCH:    ns = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: ns = ST_MEMADR;
                    OP_RTYPE:          ns = ST_EXECR;
                    OP_ITYPE:          ns = ST_EXECI;
                    OP_BRANCH:         ns = ST_BRANCH;
                    OP_JAL:            ns = (jal_en != 0) ? ST_JAL : ST_TRAP;
                    default:           ns = ST_TRAP;
                endcase
            end
            ST_MEMADR:   ns = op[5] ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  ns = mem_ready ? ST_MEMWB : ST_MEMREAD;
            ST_MEMWRITE: ns = mem_ready ? ST_FETCH : ST_MEMWRITE;
            ST_MEMWB, ST_ALUWB, ST_BRANCH: ns = ST_FETCH;
            ST_EXECR, ST_EXECI, ST_JAL:    ns = ST_ALUWB;
            default:     ns = ST_TRAP;
        endcase
        m_run[d]  = stalled ? m_run[d] + 1 : 0;
        timed_out = (to != 0) && (m_run[d] > to);
        if (timed_out) ns = ST_TRAP;
        if (ns == ST_TRAP && s != ST_TRAP) begin
            m_trap[d]  = 1'b1;
            m_cause[d] = timed_out ? 2'd2 : 2'd1;
        end
        m_st[d] = ns;
    endfunction

    task automatic tick();
        #1;
        chk($sformatf("word_a_st%0d", m_st[0]), 32'(obs_a), 32'(exp_word(0)));
        chk($sformatf("word_b_st%0d", m_st[1]), 32'(obs_b), 32'(exp_word(1)));
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        chk("rst_async_state_a", 32'(state_a), 32'(ST_FETCH));
        chk("rst_async_trap_b", 32'(trap_b), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; op = OP_RTYPE; funct3 = 3'd0; funct7 = 1'b0;
        ZeroF = 1'b0; SignF = 1'b0; mem_ready = 1'b1;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        #1;
        chk("rst_pcwrite_forced", 32'(PCWrite_a), 32'd0);
        chk("rst_irwrite_forced", 32'(IRWrite_b), 32'd0);
        chk("rst_cause", 32'(cause_a), 32'd0);
        tick();
        rst_n = 1'b1;

        // add: FETCH, DECODE, EXECR, ALUWB, back to FETCH
        tick(); tick();
        #1;
        chk("add_execr_state", 32'(state_a), 32'd6);
        chk("add_aluctl", 32'(ALUControl_a), 32'd0);
        tick();
        #1;
        chk("add_regwrite_aluwb", 32'(RegWrite_a), 32'd1);
        tick();
        #1;
        chk("add_four_cycles", 32'(state_a), 32'd0);

        funct7 = 1'b1;
        tick(); tick();
        #1;
        chk("sub_aluctl", 32'(ALUControl_a), 32'd2);
        chk("sub_aluctl_wide", 32'(ALUControl_b), 32'd2);
        tick(); tick();

        op = OP_ITYPE;
        tick(); tick();
        #1;
        chk("addi_execi_state", 32'(state_a), 32'd7);
        chk("addi_f7_aluctl", 32'(ALUControl_a), 32'd0);
        tick(); tick();

        // lw with three stalled MEMREAD cycles; the timeout config traps on the third
        op = OP_LOAD; funct7 = 1'b0; funct3 = 3'd2;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        tick(); tick(); tick();
        #1;
        chk("lw_stalled_state", 32'(state_a), 32'd3);
        chk("lw_timeout_state_b", 32'(state_b), 32'd11);
        chk("lw_timeout_cause_b", 32'(cause_b), 32'd2);
        mem_ready = 1'b1;
        tick(); tick();
        #1;
        chk("lw_eight_cycles", 32'(state_a), 32'd0);
        apply_reset();

        op = OP_BRANCH; funct3 = 3'd5; SignF = 1'b1;
        tick(); tick();
        #1;
        chk("bge_not_taken", 32'(PCWrite_a), 32'd0);
        SignF = 1'b0;
        #1;
        chk("bge_taken", 32'(PCWrite_a), 32'd1);
        tick();
        funct3 = 3'd2;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            {ZeroF, SignF} = 2'(i);
            #1;
            chk($sformatf("br_f3_010_flags%0d", i), 32'(PCWrite_a), 32'd0);
        end
        tick();

        op = 7'b1111111;
        tick(); tick();
        #1;
        chk("illegal_state", 32'(state_a), 32'd11);
        chk("illegal_trap", 32'(trap_a), 32'd1);
        chk("illegal_cause", 32'(cause_a), 32'd1);
        repeat (20) tick();
        #1;
        chk("trap_sticky", 32'(state_a), 32'd11);
        apply_reset();
        #1;
        chk("trap_cleared", 32'(trap_a), 32'd0);

        mem_ready = 1'b0;
        tick(); tick();
        #1;
        chk("fetch_stall_at_limit", 32'(state_b), 32'd0);
        tick();
        #1;
        chk("fetch_timeout_state", 32'(state_b), 32'd11);
        chk("fetch_timeout_cause", 32'(cause_b), 32'd2);
        chk("fetch_no_timeout_a", 32'(state_a), 32'd0);
        apply_reset();

        op = OP_JAL; mem_ready = 1'b1;
        tick(); tick();
        #1;
        chk("jal_state", 32'(state_a), 32'd10);
        chk("jal_pcwrite", 32'(PCWrite_a), 32'd1);
        chk("jal_disabled_cause", 32'(cause_b), 32'd1);
        tick();
        #1;
        chk("jal_to_aluwb", 32'(state_a), 32'd8);
        tick();
        apply_reset();

        op = OP_STORE;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        chk("sw_memwrite_held", 32'(MemWrite_a), 32'd1);
        apply_reset();
        chk("sw_memwrite_async_drop", 32'(MemWrite_a), 32'd0);
        mem_ready = 1'b1;

        for (int n = 0; n < 600; n++) begin
            logic [31:0] r;
            int k;
            r = $urandom();
            k = int'($urandom_range(0, 9));
            case (k)
                0: op = OP_LOAD;
                1: op = OP_STORE;
                2, 3: op = OP_RTYPE;
                4: op = OP_ITYPE;
                5, 6: op = OP_BRANCH;
                7: op = OP_JAL;
                default: op = r[6:0];
            endcase
            funct3    = r[9:7];
            funct7    = r[10];
            ZeroF     = r[11];
            SignF     = r[12];
            mem_ready = (r[14:13] != 2'b00);
            tick();
            if ((m_trap[0] && m_trap[1]) || ((m_trap[0] || m_trap[1]) && r[17:15] == 3'd0)
                || r[24:20] == 5'd0) begin
                apply_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle decoder: one FSM sequences fetch, decode, execute, memory and writeback over several clocks, sharing one ALU and one unified memory port.
- Adds a memory-ready handshake with a parametrised timeout, JAL and BGE support, a sticky trap state, and a parametrised ALUControl width.
- Sits between the instruction register and the datapath muxes, register file and memory enables.

Parameters:
- ALUCTRL_W, 3: ALUControl width, must be >=3; bits above [2:0] are always 0.
- ENABLE_JAL, 1: 1 decodes op 1101111 as JAL; 0 treats it as illegal.
- WAIT_TIMEOUT, 0: maximum consecutive stall cycles on mem_ready before trapping; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode from the instruction register.
- funct3  in  3  funct3 from the instruction register.
- funct7  in  1  instruction bit 30.
- ZeroF  in  1  ALU zero flag.
- SignF  in  1  ALU result sign flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register and OldPC enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B operand: 00 = rs2, 01 = imm, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  ALUCTRL_W  ALU operation: 000 = add, 010 = sub, else per funct3.
- state  out  4  current state encoding (debug).
- trap  out  1  sticky trap indicator.
- trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11.
- Outputs are Moore functions of state. Exceptions: PCWrite/IRWrite in FETCH and PCWrite in BRANCH, noted below.
- Any output not listed for a state is 0.
- Reset (rst_n low, asynchronous):
  - state = FETCH, trap = 0, trap_cause = 00, stall counter = 0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced 0 while rst_n is low, including mid-instruction.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Advance to DECODE on mem_ready, else stay.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add.
  - ImmSrc = 11 if op==1101111, else 10.
  - Next state:
    - op 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECR.
    - 0010011 -> EXECI.
    - 1100011 -> BRANCH.
    - 1101111 with ENABLE_JAL=1 -> JAL.
    - Anything else -> TRAP with cause 01.
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, add.
  - ImmSrc = 01 if op[5]=1, else 00.
  - Next: MEMWRITE if op[5]=1, else MEMREAD.
- MEMREAD: AdrSrc=1, ResultSrc=00; advance to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready; then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl per decode rule below; next ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, decode rule; next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = taken, computed combinationally:
    - funct3 000: ZeroF.
    - 001: !ZeroF.
    - 100: SignF.
    - 101: !SignF.
    - Others: 0.
  - Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next ALUWB (writes OldPC+4 to rd).
- ALUControl decode rule:
  - funct3 000: 010 (sub) if op[5] & funct7, else 000 (add).
  - Any other funct3: ALUControl[2:0] = funct3.
  - Result zero-extended to ALUCTRL_W.
- Stall counter (only when WAIT_TIMEOUT > 0):
  - Width clog2(WAIT_TIMEOUT+1).
  - Increments each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - If the counter equals WAIT_TIMEOUT while still waiting, next state is TRAP with cause 10.
  - mem_ready=1 in that same cycle wins: normal advance, no trap.
- TRAP:
  - All enables 0, trap=1, trap_cause held.
  - No exit except reset.
  - trap and trap_cause are registered, asserting the cycle state becomes TRAP.

Test Plan:
- add, op=0110011 f3=000 f7=0, mem_ready=1 -> states 0,1,6,8,0; ALUControl 000 in EXECR; RegWrite=1 only in ALUWB; instruction takes 4 cycles.
- sub (f7=1), then addi with f7 bit=1 -> sub gives ALUControl 010; addi gives 000 (op[5]=0).
- lw with mem_ready low 3 cycles in MEMREAD, WAIT_TIMEOUT=0 -> stays in state 3 for 3 extra cycles, then 4, then 0; total 8 cycles.
- Branches with f3=101:
  - SignF=1 -> PCWrite=0 in BRANCH.
  - SignF=0 -> PCWrite=1.
  - f3=010 -> PCWrite=0 for any flags.
- op=1111111 -> TRAP at cycle 3, trap=1, cause=01; persists 20 cycles; rst_n pulse -> state 0, trap=0.
- WAIT_TIMEOUT=2, mem_ready held 0 in FETCH -> TRAP cause 10 after the counter reaches 2.
- ENABLE_JAL=0 with jal -> cause 01.
- rst_n low during MEMWRITE -> MemWrite drops immediately, asynchronously.
